// File: rtl/modular_mult_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : modular_mult_pipe
//  Description : 4-stage pipelined (a*b) mod q multiplier for a fixed odd q,
//                using Barrett reduction, with a tag/range-error sideband.
//  Revision    : 1.0 - initial release
// ============================================================================
module modular_mult_pipe #(
    parameter int              WIDTH   = 30,
    parameter longint unsigned MODULUS = 64'd1073479681,
    parameter int              TAG_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_c,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_range_err
);

    localparam logic [WIDTH-1:0]   c_q      = MODULUS[WIDTH-1:0];
    localparam logic [WIDTH+1:0]   c_q_x    = {2'b00, c_q};
    localparam logic [2*WIDTH:0]   c_pow    = {1'b1, {(2*WIDTH){1'b0}}};
    localparam logic [2*WIDTH:0]   c_q_wide = {{(WIDTH+1){1'b0}}, c_q};
    // mu = floor(2^(2W)/q); it lies strictly between 2^W and 2^(W+1).
    localparam logic [WIDTH:0]     c_mu     = (WIDTH+1)'(c_pow / c_q_wide);
    localparam logic [2*WIDTH+1:0] c_mu_x   = {{(WIDTH+1){1'b0}}, c_mu};

    // Whole pipe moves together; held only while a result waits downstream.
    logic w_en;
    assign w_en     = rst | ~(out_valid & ~out_ready);
    assign in_ready = w_en;

    // Stage registers (datapath is not reset)
    logic [WIDTH-1:0]   r_a1, r_b1;
    logic [TAG_W-1:0]   r_tag1, r_tag2, r_tag3;
    logic               r_err1, r_err2, r_err3;
    logic               r_v1, r_v2, r_v3;
    logic [2*WIDTH-1:0] r_x2;
    logic [WIDTH+1:0]   r_x3_lo;
    logic [WIDTH:0]     r_qh3;

    logic [2*WIDTH+1:0] w_xs_x;
    logic [WIDTH+1:0]   w_qq;
    logic [WIDTH+1:0]   w_r0;
    logic [WIDTH+1:0]   w_r1;
    logic [WIDTH-1:0]   w_r2;

    // Quotient estimate from the top W+1 product bits; it undershoots the
    // true quotient by at most 2, so the remainder below is < 3q.
    assign w_xs_x = {{(WIDTH+1){1'b0}}, r_x2[2*WIDTH-1:WIDTH-1]};

    // Remainder is known to fit in W+2 bits, so only low bits are formed.
    assign w_qq = {1'b0, r_qh3} * c_q_x;
    assign w_r0 = r_x3_lo - w_qq;
    assign w_r1 = (w_r0 >= c_q_x) ? (w_r0 - c_q_x) : w_r0;
    assign w_r2 = (w_r1 >= c_q_x) ? WIDTH'(w_r1 - c_q_x) : WIDTH'(w_r1);

    always_ff @(posedge clk) begin
        if (w_en) begin
            r_a1    <= in_a;
            r_b1    <= in_b;
            r_tag1  <= in_tag;
            r_err1  <= (in_a >= c_q) || (in_b >= c_q);

            r_x2    <= {{WIDTH{1'b0}}, r_a1} * {{WIDTH{1'b0}}, r_b1};
            r_tag2  <= r_tag1;
            r_err2  <= r_err1;

            r_x3_lo <= r_x2[WIDTH+1:0];
            r_qh3   <= (WIDTH+1)'((w_xs_x * c_mu_x) >> (WIDTH+1));
            r_tag3  <= r_tag2;
            r_err3  <= r_err2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1          <= 1'b0;
            r_v2          <= 1'b0;
            r_v3          <= 1'b0;
            out_valid     <= 1'b0;
            out_c         <= '0;
            out_tag       <= '0;
            out_range_err <= 1'b0;
        end else if (w_en) begin
            r_v1          <= in_valid;
            r_v2          <= r_v1;
            r_v3          <= r_v2;
            out_valid     <= r_v3;
            out_c         <= w_r2;
            out_tag       <= r_tag3;
            out_range_err <= r_err3;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_modular_mult_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_modular_mult_pipe
//  Description : Scoreboard bench for modular_mult_pipe (default parameters).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_modular_mult_pipe;

    localparam int              W   = 30;
    localparam int              TW  = 8;
    localparam longint unsigned Q   = 64'd1073479681;
    localparam int              N_RANDOM = 20000;

    typedef struct packed {
        logic [W-1:0]  c;
        logic [TW-1:0] tag;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_c;
    logic [TW-1:0] out_tag;
    logic          out_range_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    modular_mult_pipe #(.WIDTH(W), .MODULUS(Q), .TAG_W(TW)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_tag        (in_tag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_c         (out_c),
        .out_tag       (out_tag),
        .out_range_err (out_range_err)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] t);
        exp_t e;
        longint unsigned p;
        p     = 64'(a) * 64'(b);
        e.c   = W'(p % Q);
        e.tag = t;
        e.err = (64'(a) >= Q) || (64'(b) >= Q);
        return e;
    endfunction

    // Handshakes are observed mid-cycle, ahead of the edge that commits them.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check_value("spurious_out_valid", 64'd1, 64'd0);
                end else begin
                    check_value("out_c", 64'(out_c), 64'(sb[0].c));
                    check_value("out_tag", 64'(out_tag), 64'(sb[0].tag));
                    check_value("out_range_err", 64'(out_range_err), 64'(sb[0].err));
                    if (out_ready) void'(sb.pop_front());
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_a, in_b, in_tag));
        end
    end

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return W'(Q - 1);
            1:       return {W{1'b1}};
            2:       return W'(Q);
            3:       return '0;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] t);
        int lat;
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = a; in_b = b; in_tag = t;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (lat < 12) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        check_value("latency", 64'(lat), 64'd4);
    endtask

    task automatic drain(input string tag);
        int n;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check_value(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [23:0] ov;
        int          quiet;
        int          sent;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_tag = '0;

        // Reset state, with out_ready low to show in_ready does not depend on it
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("rst_out_valid", 64'(out_valid), 64'd0);
        check_value("rst_out_c", 64'(out_c), 64'd0);
        check_value("rst_out_tag", 64'(out_tag), 64'd0);
        check_value("rst_out_range_err", 64'(out_range_err), 64'd0);
        check_value("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_value("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Directed products and range cases
        directed(30'd2, 30'd3, 8'hA1);
        directed(30'd0, W'(Q - 1), 8'hA2);
        directed(W'(Q - 1), W'(Q - 1), 8'hA3);
        directed(30'h2000_0000, 30'd4, 8'hA4);
        directed({W{1'b1}}, 30'd1, 8'hA5);
        directed(W'(Q - 1), 30'd1, 8'hA6);
        drain("drain_directed");

        // Back-to-back: 16 ops, outputs expected in cycles 4..19
        for (int k = 0; k < 24; k++) begin
            @(posedge clk); #1;
            if (k < 16) begin
                in_valid = 1'b1;
                in_a = W'($urandom); in_b = W'($urandom); in_tag = TW'(k);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            ov[k] = out_valid;
        end
        check_value("b2b_valid_pattern", 64'(ov), 64'h0F_FFF0);
        drain("drain_b2b");

        // Stall with a full pipe
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            in_valid  = 1'b1;
            in_a      = rand_operand(); in_b = rand_operand(); in_tag = TW'(8'h40 + k);
            out_ready = !(k >= 6 && k <= 10);
            @(negedge clk);
            if (!out_ready) check_value("stall_in_ready", 64'(in_ready), 64'd0);
        end
        drain("drain_stall");

        // Reset with three operations in flight
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_a = W'($urandom); in_b = W'($urandom); in_tag = TW'(8'h80 + k);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        quiet = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) quiet++;
        end
        check_value("post_rst_quiet", 64'(quiet), 64'd0);
        directed(30'd12345, 30'd67890, 8'h90);
        drain("drain_rst");

        // Random traffic with random back-pressure
        sent = 0;
        while (sent < N_RANDOM) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = rand_operand();
            in_b      = rand_operand();
            in_tag    = TW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
        end
        drain("drain_random");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
